// File: rtl/logic_2.sv
// -----------------------------------------------------------------------------
// logic_2 : fault-injectable 12-gate logic network with a golden reference copy.
//
// Two copies of the same combinational network are evaluated every cycle:
// a golden copy that is never faulted and a faultable copy in which exactly one
// net (selected by fault_sel) can be stuck at fault_val. Both copies are
// registered, and any disagreement between them is flagged by detect (per
// cycle) and detect_sticky (accumulated until cleared).
//
// Ports
//   clk            in   1  rising-edge clock
//   rst_n          in   1  asynchronous active-low reset
//   a, b, c, e     in   1  primary network inputs
//   fault_en       in   1  enables stuck-at injection on the faultable copy
//   fault_sel      in   5  net selector (1..16 valid, others = no fault)
//   fault_val      in   1  stuck-at value forced onto the selected net
//   clr            in   1  synchronous clear of detect_sticky (set wins)
//   y, z           out  1  registered outputs of the faultable copy
//   y_good, z_good out  1  registered outputs of the golden copy
//   detect         out  1  registered mismatch between the two copies
//   detect_sticky  out  1  registered sticky OR of detect
// -----------------------------------------------------------------------------
module logic_2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       e,
  input  logic       fault_en,
  input  logic [4:0] fault_sel,
  input  logic       fault_val,
  input  logic       clr,
  output logic       y,
  output logic       z,
  output logic       y_good,
  output logic       z_good,
  output logic       detect,
  output logic       detect_sticky
);

  // Selector codes for each faultable net; anything else means "no fault".
  typedef enum logic [4:0] {
    NET_NONE = 5'd0,
    NET_A    = 5'd1,
    NET_B    = 5'd2,
    NET_C    = 5'd3,
    NET_D    = 5'd4,
    NET_E    = 5'd5,
    NET_F    = 5'd6,
    NET_G    = 5'd7,
    NET_H    = 5'd8,
    NET_J    = 5'd9,
    NET_K    = 5'd10,
    NET_W    = 5'd11,
    NET_X    = 5'd12,
    NET_P    = 5'd13,
    NET_Q    = 5'd14,
    NET_Y    = 5'd15,
    NET_Z    = 5'd16
  } net_e;

  // Returns the net value as seen by downstream gates: the computed value, or
  // the stuck-at value when this net is the one selected for injection.
  function automatic logic pick(input logic  net_val,
                                input net_e  code,
                                input logic  en,
                                input logic [4:0] sel,
                                input logic  val);
    return (en && (sel == code)) ? val : net_val;
  endfunction

  // Evaluates the whole network in topological order. Each net is passed
  // through pick() before anything downstream reads it, so a fault propagates
  // exactly as a physical stuck-at would. Returns {y, z}.
  function automatic logic [1:0] eval_net(input logic in_a, input logic in_b,
                                          input logic in_c, input logic in_e,
                                          input logic en,
                                          input logic [4:0] sel,
                                          input logic val);
    logic na, nb, nc, ne, nd, nf, ng, nh, nj, nk, nw, nx, np, nq, ny, nz;
    // NOTE: blocking assignments here are intentional; each line must see the
    // value computed by the line above it within the same evaluation.
    na = pick(in_a,          NET_A, en, sel, val);
    nb = pick(in_b,          NET_B, en, sel, val);
    nc = pick(in_c,          NET_C, en, sel, val);
    ne = pick(in_e,          NET_E, en, sel, val);
    nd = pick(na & nb,       NET_D, en, sel, val);
    nf = pick(nb | nc,       NET_F, en, sel, val);
    ng = pick(nc ^ ne,       NET_G, en, sel, val);
    nh = pick(~(nd | nf),    NET_H, en, sel, val);
    nj = pick(nf & ng,       NET_J, en, sel, val);
    nk = pick(na ^ ne,       NET_K, en, sel, val);
    nw = pick(nh | nj,       NET_W, en, sel, val);
    nx = pick(~(nj & nk),    NET_X, en, sel, val);
    np = pick(nd ^ nk,       NET_P, en, sel, val);
    nq = pick(nw & nx,       NET_Q, en, sel, val);
    ny = pick(np | nq,       NET_Y, en, sel, val);
    nz = pick(nx ^ nw,       NET_Z, en, sel, val);
    return {ny, nz};
  endfunction

  logic y_next, z_next, y_good_next, z_good_next, detect_next;

  always_comb begin
    // NOTE: every signal is assigned on every pass through this block, so no
    // latch can be inferred.
    {y_next, z_next}           = eval_net(a, b, c, e, fault_en, fault_sel, fault_val);
    {y_good_next, z_good_next} = eval_net(a, b, c, e, 1'b0, NET_NONE, 1'b0);
    detect_next = (y_next != y_good_next) | (z_next != z_good_next);
  end

  // Sticky flag: the incoming detect sets it, and that set overrides clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y             <= 1'b0;
      z             <= 1'b0;
      y_good        <= 1'b0;
      z_good        <= 1'b0;
      detect        <= 1'b0;
      detect_sticky <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update together from
      // values sampled before the edge.
      y             <= y_next;
      z             <= z_next;
      y_good        <= y_good_next;
      z_good        <= z_good_next;
      detect        <= detect_next;
      detect_sticky <= detect_next | (detect_sticky & ~clr);
    end
  end

endmodule

// File: tb/tb_logic_2.sv
// -----------------------------------------------------------------------------
// tb_logic_2 : self-checking bench for logic_2.
// The reference model describes the network as a gate table over an array of
// 16 nets indexed by their selector code and applies the stuck-at override
// after each net is produced.
// -----------------------------------------------------------------------------
module tb_logic_2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a, b, c, e;
  logic       fault_en;
  logic [4:0] fault_sel;
  logic       fault_val;
  logic       clr;
  logic       y, z, y_good, z_good, detect, detect_sticky;

  int tests_run = 0;
  int tests_failed = 0;

  // Expected register state
  logic exp_y, exp_z, exp_yg, exp_zg, exp_det, exp_sticky;

  logic_2 dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .a             (a),
    .b             (b),
    .c             (c),
    .e             (e),
    .fault_en      (fault_en),
    .fault_sel     (fault_sel),
    .fault_val     (fault_val),
    .clr           (clr),
    .y             (y),
    .z             (z),
    .y_good        (y_good),
    .z_good        (z_good),
    .detect        (detect),
    .detect_sticky (detect_sticky)
  );

  always #5 clk = ~clk;

  typedef enum int {OP_AND, OP_OR, OP_XOR, OP_NOR, OP_NAND} op_e;
  typedef struct { int dst; op_e op; int s1; int s2; } gate_t;
  gate_t gates [12];

  initial begin
    gates[0]  = '{4,  OP_AND,  1,  2};   // d = a & b
    gates[1]  = '{6,  OP_OR,   2,  3};   // f = b | c
    gates[2]  = '{7,  OP_XOR,  3,  5};   // g = c ^ e
    gates[3]  = '{8,  OP_NOR,  4,  6};   // h = ~(d | f)
    gates[4]  = '{9,  OP_AND,  6,  7};   // j = f & g
    gates[5]  = '{10, OP_XOR,  1,  5};   // k = a ^ e
    gates[6]  = '{11, OP_OR,   8,  9};   // w = h | j
    gates[7]  = '{12, OP_NAND, 9,  10};  // x = ~(j & k)
    gates[8]  = '{13, OP_XOR,  4,  10};  // p = d ^ k
    gates[9]  = '{14, OP_AND,  11, 12};  // q = w & x
    gates[10] = '{15, OP_OR,   13, 14};  // y = p | q
    gates[11] = '{16, OP_XOR,  12, 11};  // z = x ^ w
  end

  // Returns {y, z} of the network with optional stuck-at on net 'sel'.
  function automatic logic [1:0] model(input logic ia, input logic ib,
                                       input logic ic, input logic ie,
                                       input logic en, input int sel,
                                       input logic val);
    logic net [17];
    int   fsel;
    fsel = (en && sel >= 1 && sel <= 16) ? sel : -1;
    net[1] = ia; net[2] = ib; net[3] = ic; net[5] = ie;
    foreach (net[i]) if (i == fsel && (i == 1 || i == 2 || i == 3 || i == 5)) net[i] = val;
    for (int g = 0; g < 12; g++) begin
      logic l, r, o;
      l = net[gates[g].s1];
      r = net[gates[g].s2];
      case (gates[g].op)
        OP_AND:  o = l & r;
        OP_OR:   o = l | r;
        OP_XOR:  o = l ^ r;
        OP_NOR:  o = ~(l | r);
        default: o = ~(l & r);
      endcase
      net[gates[g].dst] = (gates[g].dst == fsel) ? val : o;
    end
    return {net[15], net[16]};
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".y"},             y,             exp_y);
    check({tag, ".z"},             z,             exp_z);
    check({tag, ".y_good"},        y_good,        exp_yg);
    check({tag, ".z_good"},        z_good,        exp_zg);
    check({tag, ".detect"},        detect,        exp_det);
    check({tag, ".detect_sticky"}, detect_sticky, exp_sticky);
  endtask

  // Apply inputs away from the edge, clock once, update the model, then check.
  task automatic cycle(input logic ia, input logic ib, input logic ic,
                       input logic ie, input logic en, input logic [4:0] sel,
                       input logic val, input logic iclr, input string tag);
    logic [1:0] f, g;
    @(negedge clk);
    a = ia; b = ib; c = ic; e = ie;
    fault_en = en; fault_sel = sel; fault_val = val; clr = iclr;
    f = model(ia, ib, ic, ie, en, int'(sel), val);
    g = model(ia, ib, ic, ie, 1'b0, 0, 1'b0);
    @(posedge clk);
    #1;
    exp_y = f[1]; exp_z = f[0]; exp_yg = g[1]; exp_zg = g[0];
    exp_det = (f != g);
    exp_sticky = exp_det | (exp_sticky & ~iclr);
    check_all(tag);
  endtask

  task automatic expect_reset_values();
    exp_y = 0; exp_z = 0; exp_yg = 0; exp_zg = 0; exp_det = 0; exp_sticky = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    a = 0; b = 0; c = 0; e = 0;
    fault_en = 0; fault_sel = '0; fault_val = 0; clr = 0;
    expect_reset_values();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // All-zero vector, no fault: y=1 z=0
    cycle(0, 0, 0, 0, 0, 5'd0, 0, 0, "zeros_nofault");
    check("zeros_nofault.y_lit", y, 1'b1);

    // Stuck-at-0 on d
    cycle(1, 1, 0, 0, 1, 5'd4, 0, 0, "d_sa0");
    check("d_sa0.y_lit", y, 1'b1);
    check("d_sa0.z_lit", z, 1'b1);
    check("d_sa0.yg_lit", y_good, 1'b0);

    // Undetectable: a stuck-at-1 with a=0,b=1
    cycle(0, 1, 0, 0, 1, 5'd1, 1, 0, "a_sa1_undet");
    check("a_sa1_undet.det_lit", detect, 1'b0);

    // y stuck-at-0, then an out-of-range selector, then clear
    cycle(0, 0, 0, 0, 1, 5'd15, 0, 0, "y_sa0");
    check("y_sa0.y_lit", y, 1'b0);
    cycle(0, 0, 0, 0, 1, 5'd20, 0, 0, "sel20");
    check("sel20.sticky_lit", detect_sticky, 1'b1);
    cycle(0, 0, 0, 0, 1, 5'd20, 0, 0, "sel20_hold");
    cycle(0, 0, 0, 0, 1, 5'd20, 0, 1, "clr");
    check("clr.sticky_lit", detect_sticky, 1'b0);

    // Set beats clr in the same cycle
    cycle(0, 0, 0, 0, 1, 5'd15, 0, 1, "set_over_clr");

    // Randomized sweep across all selector codes
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 5'($urandom_range(0, 31)), 1'($urandom),
            ($urandom_range(0, 7) == 0), "rand");
    end

    // Make sure something nonzero is registered, then reset with no edge
    cycle(0, 0, 0, 0, 1, 5'd15, 0, 0, "pre_reset");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    expect_reset_values();
    check_all("async_reset");
    #3;
    rst_n = 1'b1;

    // First edge after reset loads normal network values
    cycle(1, 0, 1, 1, 0, 5'd0, 0, 0, "post_reset");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
